// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake and completion bus between an instruction source and alu_op_sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned RIDX_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [RIDX_W-1:0] instr_rd;
  logic [RIDX_W-1:0] instr_ra;
  logic [RIDX_W-1:0] instr_rb;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
    input  instr_ready, done, err, result
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
    output instr_ready, done, err, result
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Two-state sequencer: reads operands from a small register file, drives the external
// combinational ALU for one cycle, then writes its Z back and pulses done/err.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned RIDX_W = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  input  logic                ld_en,
  input  logic [RIDX_W-1:0]   ld_idx,
  input  logic [DATA_W-1:0]   ld_data,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_z,
  input  logic [RIDX_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(9);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf [NREGS];
  logic [RIDX_W-1:0] rd_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q, err_q;
  logic              accept;
  logic              legal;

  always_comb begin
    state_d         = state_q;
    bus.instr_ready = (state_q == IDLE);
    accept          = bus.instr_valid && (state_q == IDLE);
    legal           = (alu_op <= OP_LAST_LEGAL);
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      rd_q     <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // Load is applied first so a same-index writeback below overrides it.
      if (ld_en) rf[ld_idx] <= ld_data;
      if (accept) begin
        alu_op <= bus.instr_op;
        alu_a  <= rf[bus.instr_ra];
        alu_b  <= rf[bus.instr_rb];
        rd_q   <= bus.instr_rd;
      end
      if (state_q == EXEC) begin
        if (legal) begin
          rf[rd_q] <= alu_z;
          result_q <= alu_z;
        end
        done_q <= 1'b1;
        err_q  <= !legal;
        alu_op <= '0;
        alu_a  <= '0;
        alu_b  <= '0;
      end
    end
  end

  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign dbg_data   = rf[dbg_sel];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 8-bit ALU on the alu_* bus.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_en;
  logic [1:0] ld_idx;
  logic [7:0] ld_data;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_z;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [8:0] exp_q [$];  // {err, result}

  alu_op_sequencer_if #(.DATA_W(8), .OP_W(4), .RIDX_W(2)) bus ();

  alu_op_sequencer #(.DATA_W(8), .OP_W(4), .NREGS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ld_en    (ld_en),
    .ld_idx   (ld_idx),
    .ld_data  (ld_data),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_z    (alu_z),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Illegal opcodes produce a distinctive value that must never be written back.
  always_comb begin
    case (alu_op)
      4'd0:    alu_z = 8'h00;
      4'd1:    alu_z = 8'h01;
      4'd2:    alu_z = alu_a;
      4'd3:    alu_z = alu_b;
      4'd4:    alu_z = alu_a + alu_b;
      4'd5:    alu_z = 8'h00 - alu_a;
      4'd6:    alu_z = alu_a & alu_b;
      4'd7:    alu_z = alu_a | alu_b;
      4'd8:    alu_z = (alu_a == alu_b) ? 8'h01 : 8'h00;
      4'd9:    alu_z = (alu_a > alu_b) ? 8'h01 : 8'h00;
      default: alu_z = 8'hEE;
    endcase
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 9'({bus.err, bus.result}), 9'h1FF);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("done_err", 9'(bus.err), 9'(e[8]));
        check("done_result", 9'(bus.result), 9'(e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [7:0] d);
    ld_en = 1'b1; ld_idx = idx; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic rd_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    check(name, 9'(dbg_data), 9'(exp));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.instr_ready) check("ready_timeout", 9'(bus.instr_ready), 9'd1);
  endtask

  // Issues one instruction; ends in its done cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, ra, rb,
                       input logic [7:0] exp_a, exp_b, exp_res, input logic exp_err);
    wait_ready();
    bus.instr_valid = 1'b1; bus.instr_op = op;
    bus.instr_rd = rd; bus.instr_ra = ra; bus.instr_rb = rb;
    exp_q.push_back({exp_err, exp_res});
    tick();
    bus.instr_valid = 1'b0;
    check("exec_op", 9'(alu_op), 9'(op));
    check("exec_a", 9'(alu_a), 9'(exp_a));
    check("exec_b", 9'(alu_b), 9'(exp_b));
    check("exec_not_ready", 9'(bus.instr_ready), 9'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0; dbg_sel = '0;
    bus.instr_valid = 1'b0; bus.instr_op = '0;
    bus.instr_rd = '0; bus.instr_ra = '0; bus.instr_rb = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 9'(bus.instr_ready), 9'd1);
    check("rst_done", 9'({bus.done, bus.err}), 9'd0);
    check("rst_result", 9'(bus.result), 9'h00);
    check("rst_alu", 9'(alu_op) | 9'(alu_a) | 9'(alu_b), 9'd0);
    for (int i = 0; i < 4; i++) rd_reg("rst_rf", 2'(i), 8'h00);

    // Add
    load(2'd0, 8'h05); load(2'd1, 8'h03);
    issue(4'd4, 2'd2, 2'd0, 2'd1, 8'h05, 8'h03, 8'h08, 1'b0);
    rd_reg("add_r2", 2'd2, 8'h08);

    // Overflowing add, then negate
    load(2'd0, 8'hFF); load(2'd1, 8'h02);
    issue(4'd4, 2'd3, 2'd0, 2'd1, 8'hFF, 8'h02, 8'h01, 1'b0);
    issue(4'd5, 2'd2, 2'd1, 2'd0, 8'h02, 8'hFF, 8'hFE, 1'b0);
    rd_reg("ovf_r3", 2'd3, 8'h01);
    rd_reg("neg_r2", 2'd2, 8'hFE);

    // Unsigned compares
    load(2'd0, 8'h80); load(2'd1, 8'h7F);
    issue(4'd9, 2'd2, 2'd1, 2'd0, 8'h7F, 8'h80, 8'h00, 1'b0);
    rd_reg("gt_false_r2", 2'd2, 8'h00);
    issue(4'd9, 2'd2, 2'd0, 2'd1, 8'h80, 8'h7F, 8'h01, 1'b0);
    issue(4'd8, 2'd3, 2'd0, 2'd0, 8'h80, 8'h80, 8'h01, 1'b0);
    rd_reg("gt_r2", 2'd2, 8'h01);
    rd_reg("eq_r3", 2'd3, 8'h01);

    // Illegal opcodes leave rf and result untouched
    load(2'd2, 8'h55);
    issue(4'd12, 2'd2, 2'd0, 2'd1, 8'h80, 8'h7F, 8'h01, 1'b1);
    rd_reg("ill12_r2", 2'd2, 8'h55);
    issue(4'd10, 2'd3, 2'd0, 2'd1, 8'h80, 8'h7F, 8'h01, 1'b1);
    issue(4'd15, 2'd3, 2'd1, 2'd0, 8'h7F, 8'h80, 8'h01, 1'b1);
    rd_reg("ill_r3", 2'd3, 8'h01);

    // Back-to-back dependency, load collides with the first writeback
    load(2'd0, 8'h05); load(2'd1, 8'h03);
    bus.instr_valid = 1'b1; bus.instr_op = 4'd4;
    bus.instr_rd = 2'd2; bus.instr_ra = 2'd0; bus.instr_rb = 2'd1;
    exp_q.push_back({1'b0, 8'h08});
    tick();
    check("b2b_exec1_a", 9'(alu_a), 9'h05);
    bus.instr_ra = 2'd2;
    ld_en = 1'b1; ld_idx = 2'd2; ld_data = 8'hAA;
    tick();
    ld_en = 1'b0;
    check("b2b_ready_again", 9'(bus.instr_ready), 9'd1);
    rd_reg("b2b_wb_wins", 2'd2, 8'h08);
    exp_q.push_back({1'b0, 8'h0B});
    tick();
    bus.instr_valid = 1'b0;
    check("b2b_exec2_a", 9'(alu_a), 9'h08);
    check("b2b_exec2_busy", 9'(bus.instr_ready), 9'd0);
    tick();
    rd_reg("b2b_r2", 2'd2, 8'h0B);

    // Reset while in EXEC aborts the instruction
    load(2'd0, 8'h05); load(2'd1, 8'h03);
    bus.instr_valid = 1'b1; bus.instr_op = 4'd4;
    bus.instr_rd = 2'd2; bus.instr_ra = 2'd0; bus.instr_rb = 2'd1;
    tick();
    bus.instr_valid = 1'b0;
    check("abort_exec_a", 9'(alu_a), 9'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 9'(bus.instr_ready), 9'd1);
    check("abort_no_done", 9'(bus.done), 9'd0);
    check("abort_alu", 9'(alu_op) | 9'(alu_a) | 9'(alu_b), 9'd0);
    for (int i = 0; i < 4; i++) rd_reg("abort_rf", 2'(i), 8'h00);
    tick(); tick();
    check("abort_still_no_done", 9'(bus.done), 9'd0);
    check("scoreboard_drained", 9'(exp_q.size()), 9'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
